// File: rtl/param_uart_tx.sv
// Parametrised UART transmitter: 5-9 data bits, optional even/odd parity, 1 or 2 stop bits.
// The bit period is latched per frame from baud_div, and back-to-back frames leave no idle gap on the line.
module param_uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 arst_n,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_bit,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic [BIT_W-1:0]     bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 par_d;
    logic                 tx_bit_q;
    logic                 tx_ready_q;
    logic                 tx_busy_q;
    logic                 tx_done_q;
    logic                 accept;
    logic                 bit_end;
    logic                 last_stop;

    assign accept    = tx_valid && tx_ready_q;
    assign bit_end   = (cnt_q == div_q - DIV_WIDTH'(1));
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
    // Divisors below 2 would leave no room for the early tx_done/tx_ready decode.
    assign div_d     = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
    assign par_d     = (PARITY == 2) ? ~^tx_data : ^tx_data;

    assign tx_bit   = tx_bit_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

    always_ff @(posedge clock) begin
        if (accept) begin
            shift_q <= tx_data;
            div_q   <= div_d;
            par_q   <= par_d;
        end else if (state_q == DATA && bit_end) begin
            shift_q <= shift_q >> 1;
        end
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_bit_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (accept) begin
                state_q    <= START;
                cnt_q      <= '0;
                bit_idx_q  <= '0;
                stop_idx_q <= 1'b0;
                tx_bit_q   <= 1'b0;
                tx_ready_q <= 1'b0;
                tx_busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    START: begin
                        if (bit_end) begin
                            state_q  <= DATA;
                            cnt_q    <= '0;
                            tx_bit_q <= shift_q[0];
                        end else begin
                            cnt_q <= cnt_q + DIV_WIDTH'(1);
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            cnt_q <= '0;
                            if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                                if (PARITY != 0) begin
                                    state_q  <= PAR;
                                    tx_bit_q <= par_q;
                                end else begin
                                    state_q    <= STOP;
                                    stop_idx_q <= 1'b0;
                                    tx_bit_q   <= 1'b1;
                                end
                            end else begin
                                bit_idx_q <= bit_idx_q + BIT_W'(1);
                                tx_bit_q  <= shift_q[1];
                            end
                        end else begin
                            cnt_q <= cnt_q + DIV_WIDTH'(1);
                        end
                    end
                    PAR: begin
                        if (bit_end) begin
                            state_q    <= STOP;
                            cnt_q      <= '0;
                            stop_idx_q <= 1'b0;
                            tx_bit_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + DIV_WIDTH'(1);
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            cnt_q <= '0;
                            if (last_stop) begin
                                state_q   <= IDLE;
                                tx_busy_q <= 1'b0;
                            end else begin
                                stop_idx_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + DIV_WIDTH'(1);
                            // Registered done/ready must rise one edge before the final stop cycle.
                            if (last_stop && cnt_q == div_q - DIV_WIDTH'(2)) begin
                                tx_done_q  <= 1'b1;
                                tx_ready_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        tx_bit_q   <= 1'b1;
                        tx_ready_q <= 1'b1;
                        tx_busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_param_uart_tx.sv
// Directed bench for param_uart_tx with three frame formats: 8N1, 7E2 and 8O1.
// Each scenario walks the line cycle by cycle against hand-built bit sequences.
module tb_param_uart_tx;
    logic        clock = 1'b0;
    logic        arst_n = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic [8:0]  tx_data [3];
    logic        tx_valid [3];
    logic        tx_ready [3];
    logic        tx_bit [3];
    logic        tx_busy [3];
    logic        tx_done [3];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    param_uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_WIDTH(16)) dut_8n1 (
        .clock(clock), .arst_n(arst_n), .baud_div(baud_div), .tx_data(tx_data[0][7:0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx_bit(tx_bit[0]),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

    param_uart_tx #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DIV_WIDTH(16)) dut_7e2 (
        .clock(clock), .arst_n(arst_n), .baud_div(baud_div), .tx_data(tx_data[1][6:0]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx_bit(tx_bit[1]),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

    param_uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_WIDTH(16)) dut_8o1 (
        .clock(clock), .arst_n(arst_n), .baud_div(baud_div), .tx_data(tx_data[2][7:0]),
        .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .tx_bit(tx_bit[2]),
        .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

    // Present one payload and return just after its accept edge; cycle 0 is the next low phase.
    task automatic start_frame(input int idx, input logic [8:0] data, input logic [15:0] div);
        @(posedge clock);
        #1;
        tx_data[idx]  = data;
        tx_valid[idx] = 1'b1;
        baud_div      = div;
        @(posedge clock);
        #1;
        tx_valid[idx] = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({tx_bit[i], tx_ready[i], tx_busy[i], tx_done[i]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got bit/rdy/busy/done=%b%b%b%b want 1100",
                         i, tx_bit[i], tx_ready[i], tx_busy[i], tx_done[i]);
            end
        end
        @(posedge clock);
        #1;
        arst_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (tx_bit[0] !== 1'b1 || tx_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_release: got bit=%b rdy=%b want 1 1", tx_bit[0], tx_ready[0]);
        end
    endtask

    task automatic test_8n1_a5();
        logic [9:0] exp = 10'b1_10100101_0;
        start_frame(0, 9'h0A5, 16'd4);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            n_checks++;
            if (tx_bit[0] !== exp[k / 4]) begin
                n_fail++;
                $display("FAIL a5_line cycle %0d: got %b want %b", k, tx_bit[0], exp[k / 4]);
            end
            n_checks++;
            if (tx_done[0] !== (k == 39) || tx_ready[0] !== (k == 39) || tx_busy[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL a5_ctrl cycle %0d: got done=%b rdy=%b busy=%b want %b %b 1",
                         k, tx_done[0], tx_ready[0], tx_busy[0], k == 39, k == 39);
            end
        end
        @(negedge clock);
        n_checks++;
        if ({tx_bit[0], tx_busy[0], tx_ready[0], tx_done[0]} !== 4'b1010) begin
            n_fail++;
            $display("FAIL a5_idle: got bit/busy/rdy/done=%b%b%b%b want 1010",
                     tx_bit[0], tx_busy[0], tx_ready[0], tx_done[0]);
        end
    endtask

    task automatic test_7e2_parity();
        logic [10:0] exp = 11'b11_0_0110101_0;
        int          dones = 0;
        start_frame(1, 9'h035, 16'd5);
        for (int k = 0; k < 55; k++) begin
            @(negedge clock);
            n_checks++;
            if (tx_bit[1] !== exp[k / 5]) begin
                n_fail++;
                $display("FAIL 7e2_line cycle %0d: got %b want %b", k, tx_bit[1], exp[k / 5]);
            end
            if (tx_done[1] === 1'b1) dones++;
            n_checks++;
            if (tx_done[1] !== (k == 54) || tx_busy[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL 7e2_ctrl cycle %0d: got done=%b busy=%b want %b 1", k, tx_done[1], tx_busy[1], k == 54);
            end
        end
        @(negedge clock);
        n_checks++;
        if (tx_busy[1] !== 1'b0 || dones != 1) begin
            n_fail++;
            $display("FAIL 7e2_end: got busy=%b dones=%0d want 0 1", tx_busy[1], dones);
        end
    endtask

    task automatic test_8o1_parity();
        logic [10:0] exp [2];
        logic [8:0]  pay [2];
        exp[0] = 11'b1_0_00000001_0;
        exp[1] = 11'b1_1_00000000_0;
        pay[0] = 9'h001;
        pay[1] = 9'h000;
        for (int f = 0; f < 2; f++) begin
            start_frame(2, pay[f], 16'd3);
            for (int k = 0; k < 33; k++) begin
                @(negedge clock);
                n_checks++;
                if (tx_bit[2] !== exp[f][k / 3] || tx_done[2] !== (k == 32)) begin
                    n_fail++;
                    $display("FAIL 8o1_frame%0d cycle %0d: got bit=%b done=%b want %b %b",
                             f, k, tx_bit[2], tx_done[2], exp[f][k / 3], k == 32);
                end
            end
            @(negedge clock);
            n_checks++;
            if (tx_busy[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL 8o1_end%0d: got busy=%b want 0", f, tx_busy[2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp = {10'b1_00100010_0, 10'b1_00010001_0};
        @(posedge clock);
        #1;
        baud_div    = 16'd4;
        tx_data[0]  = 9'h011;
        tx_valid[0] = 1'b1;
        @(posedge clock);
        #1;
        tx_data[0] = 9'h022;
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            if (k == 40) tx_valid[0] = 1'b0;
            n_checks++;
            if (tx_bit[0] !== exp[k / 4]) begin
                n_fail++;
                $display("FAIL b2b_line cycle %0d: got %b want %b", k, tx_bit[0], exp[k / 4]);
            end
            n_checks++;
            if (tx_busy[0] !== 1'b1 || tx_done[0] !== (k == 39 || k == 79) ||
                tx_ready[0] !== (k == 39 || k == 79)) begin
                n_fail++;
                $display("FAIL b2b_ctrl cycle %0d: got busy=%b done=%b rdy=%b", k, tx_busy[0], tx_done[0], tx_ready[0]);
            end
        end
        @(negedge clock);
        n_checks++;
        if (tx_busy[0] !== 1'b0 || tx_bit[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: got busy=%b bit=%b want 0 1", tx_busy[0], tx_bit[0]);
        end
    endtask

    task automatic test_mid_reset();
        logic [9:0] exp = 10'b1_00111100_0;
        start_frame(0, 9'h0A5, 16'd4);
        for (int k = 0; k < 18; k++) @(negedge clock);
        n_checks++;
        if (tx_bit[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_line: got %b want 0", tx_bit[0]);
        end
        arst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_bit[0], tx_busy[0], tx_ready[0], tx_done[0]} !== 4'b1010) begin
            n_fail++;
            $display("FAIL async_reset: got bit/busy/rdy/done=%b%b%b%b want 1010",
                     tx_bit[0], tx_busy[0], tx_ready[0], tx_done[0]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++;
            if (tx_done[0] !== 1'b0 || tx_bit[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL in_reset cycle %0d: got done=%b bit=%b want 0 1", k, tx_done[0], tx_bit[0]);
            end
        end
        @(posedge clock);
        #1;
        arst_n = 1'b1;
        start_frame(0, 9'h03C, 16'd4);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            n_checks++;
            if (tx_bit[0] !== exp[k / 4] || tx_done[0] !== (k == 39)) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d: got bit=%b done=%b want %b %b",
                         k, tx_bit[0], tx_done[0], exp[k / 4], k == 39);
            end
        end
    endtask

    task automatic test_divisor();
        logic [9:0]  exp [3];
        logic [8:0]  pay [3];
        logic [15:0] div [3];
        int          per [3];
        exp[0] = 10'b1_01011010_0;  pay[0] = 9'h05A;  div[0] = 16'd0;  per[0] = 2;
        exp[1] = 10'b1_11000011_0;  pay[1] = 9'h0C3;  div[1] = 16'd1;  per[1] = 2;
        exp[2] = 10'b1_10010110_0;  pay[2] = 9'h096;  div[2] = 16'd3;  per[2] = 3;
        for (int f = 0; f < 3; f++) begin
            start_frame(0, pay[f], div[f]);
            for (int k = 0; k < 10 * per[f]; k++) begin
                @(negedge clock);
                if (f == 2 && k == 5) begin
                    baud_div   = 16'd7;
                    tx_data[0] = 9'h0FF;
                end
                n_checks++;
                if (tx_bit[0] !== exp[f][k / per[f]] || tx_done[0] !== (k == 10 * per[f] - 1)) begin
                    n_fail++;
                    $display("FAIL div_frame%0d cycle %0d: got bit=%b done=%b want %b %b",
                             f, k, tx_bit[0], tx_done[0], exp[f][k / per[f]], k == 10 * per[f] - 1);
                end
            end
            @(negedge clock);
            n_checks++;
            if (tx_busy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL div_end%0d: got busy=%b want 0", f, tx_busy[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1_a5();
        test_7e2_parity();
        test_8o1_parity();
        test_back_to_back();
        test_mid_reset();
        test_divisor();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
